// File: rtl/collision_checker.sv
// collision_checker: sequential T-rex collision detector.
// A coarse test on the shrunk outer boxes runs first. If it overlaps, the
// checker walks every (T-rex sub-box, obstacle sub-box) pair, one pair per
// cycle, and stops at the first overlap.

package collision_pkg;

    // 44-bit packed collision box: x s12, y s12, w s10, h s10 (x in the MSBs).
    typedef struct packed {
        logic signed [11:0] x;
        logic signed [11:0] y;
        logic signed [9:0]  w;
        logic signed [9:0]  h;
    } box_t;

    // All edge arithmetic is widened, so x+w and y+h can never wrap,
    // including when an obstacle has a negative x (partly off-screen left).
    typedef logic signed [13:0] coord_t;

    // A box expressed by its edges: [xl, xh) x [yl, yh).
    typedef struct packed {
        coord_t xl;
        coord_t xh;
        coord_t yl;
        coord_t yh;
    } span_t;

    function automatic coord_t sx12(logic signed [11:0] v);
        return coord_t'(v);
    endfunction

    function automatic coord_t sx10(logic signed [9:0] v);
        return coord_t'(v);
    endfunction

    // Outer box shrunk by one pixel on every side: {x+1, y+1, w-2, h-2}.
    function automatic span_t shrink(box_t b);
        span_t s;
        s.xl = sx12(b.x) + coord_t'(1);
        s.xh = sx12(b.x) + sx10(b.w) - coord_t'(1);
        s.yl = sx12(b.y) + coord_t'(1);
        s.yh = sx12(b.y) + sx10(b.h) - coord_t'(1);
        return s;
    endfunction

    // Sub-box moved from entity-relative to absolute screen coordinates.
    function automatic span_t adjust(box_t sub, box_t org);
        span_t s;
        s.xl = sx12(sub.x) + sx12(org.x);
        s.xh = s.xl + sx10(sub.w);
        s.yl = sx12(sub.y) + sx12(org.y);
        s.yh = s.yl + sx10(sub.h);
        return s;
    endfunction

    // Strict-inequality overlap: boxes that only touch along an edge miss.
    function automatic logic overlap(span_t a, span_t b);
        return (a.xl < b.xh) && (a.xh > b.xl) && (a.yl < b.yh) && (a.yh > b.yl);
    endfunction

endpackage

module collision_checker
    import collision_pkg::*;
#(
    parameter int MAX_TREX_BOXES = 8,
    parameter int MAX_OBS_BOXES  = 8,
    localparam int TI = $clog2(MAX_TREX_BOXES),
    localparam int OI = $clog2(MAX_OBS_BOXES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  box_t          trex_outer,
    input  box_t          obs_outer,
    input  logic [TI:0]   trex_count,
    input  logic [OI:0]   obs_count,
    output logic [TI-1:0] trex_idx,
    input  box_t          trex_box,
    output logic [OI-1:0] obs_idx,
    input  box_t          obs_box,
    output logic          busy,
    output logic          done,
    output logic          hit
);

    typedef enum logic [1:0] {IDLE, OUTER, INNER, DONE} state_t;

    localparam logic [TI:0] TREX_MAX = (TI+1)'(MAX_TREX_BOXES);
    localparam logic [OI:0] OBS_MAX  = (OI+1)'(MAX_OBS_BOXES);
    localparam logic [TI:0] TREX_ONE = (TI+1)'(1);
    localparam logic [OI:0] OBS_ONE  = (OI+1)'(1);

    state_t        state;
    state_t        state_nxt;

    // Values captured at start; they stay frozen for the whole check.
    box_t          trex_lat;
    box_t          obs_lat;
    logic [TI:0]   trex_cnt;
    logic [OI:0]   obs_cnt;

    logic [TI-1:0] i_cnt;
    logic [OI-1:0] j_cnt;

    logic          outer_hit;
    logic          pair_hit;
    logic          last_i;
    logic          last_j;

    assign outer_hit = overlap(shrink(trex_lat), shrink(obs_lat))
                       && (trex_cnt != '0) && (obs_cnt != '0);
    assign pair_hit  = overlap(adjust(trex_box, trex_lat), adjust(obs_box, obs_lat));
    assign last_i    = ({1'b0, i_cnt} == (trex_cnt - TREX_ONE));
    assign last_j    = ({1'b0, j_cnt} == (obs_cnt - OBS_ONE));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register updates from values sampled at the same edge.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: defaulting first keeps every path assigned, so no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = OUTER;
            OUTER:   state_nxt = outer_hit ? INNER : DONE;
            INNER:   if (pair_hit || (last_i && last_j)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the current state; table indices are idle-zero.
    always_comb begin
        busy     = (state != IDLE);
        done     = (state == DONE);
        trex_idx = '0;
        obs_idx  = '0;
        if (state == INNER) begin
            trex_idx = i_cnt;
            obs_idx  = j_cnt;
        end
    end

    // Input capture, pair counters and the result flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trex_lat <= '0;
            obs_lat  <= '0;
            trex_cnt <= '0;
            obs_cnt  <= '0;
            i_cnt    <= '0;
            j_cnt    <= '0;
            hit      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        trex_lat <= trex_outer;
                        obs_lat  <= obs_outer;
                        trex_cnt <= (trex_count > TREX_MAX) ? TREX_MAX : trex_count;
                        obs_cnt  <= (obs_count  > OBS_MAX)  ? OBS_MAX  : obs_count;
                        i_cnt    <= '0;
                        j_cnt    <= '0;
                        hit      <= 1'b0;
                    end
                end
                OUTER: begin
                    i_cnt <= '0;
                    j_cnt <= '0;
                end
                INNER: begin
                    if (pair_hit) begin
                        hit <= 1'b1;
                    end else if (last_j) begin
                        j_cnt <= '0;
                        i_cnt <= i_cnt + 1'b1;
                    end else begin
                        j_cnt <= j_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_collision_checker.sv
// Self-checking bench for collision_checker: directed cases plus randomized
// checks against a plain-integer reference model of the collision rules.

module tb_collision_checker;
    import collision_pkg::*;

    localparam int MT = 8;
    localparam int MO = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    box_t       trex_outer;
    box_t       obs_outer;
    logic [3:0] trex_count;
    logic [3:0] obs_count;
    logic [2:0] trex_idx;
    logic [2:0] obs_idx;
    box_t       trex_box;
    box_t       obs_box;
    logic       busy;
    logic       done;
    logic       hit;

    box_t trex_tab [MT];
    box_t obs_tab  [MO];

    int n_checks = 0;
    int n_errors = 0;

    collision_checker #(.MAX_TREX_BOXES(MT), .MAX_OBS_BOXES(MO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .trex_outer (trex_outer),
        .obs_outer  (obs_outer),
        .trex_count (trex_count),
        .obs_count  (obs_count),
        .trex_idx   (trex_idx),
        .trex_box   (trex_box),
        .obs_idx    (obs_idx),
        .obs_box    (obs_box),
        .busy       (busy),
        .done       (done),
        .hit        (hit)
    );

    // Combinational box tables.
    assign trex_box = trex_tab[trex_idx];
    assign obs_box  = obs_tab[obs_idx];

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic box_t mk(input int x, input int y, input int w, input int h);
        box_t b;
        b.x = 12'(x);
        b.y = 12'(y);
        b.w = 10'(w);
        b.h = 10'(h);
        return b;
    endfunction

    // Boxes as (x, y, w, h) integers; strict overlap on both axes.
    function automatic bit ovl(input int ax, input int ay, input int aw, input int ah,
                               input int bx, input int by, input int bw, input int bh);
        return (ax < bx + bw) && (ax + aw > bx) && (ay < by + bh) && (ay + ah > by);
    endfunction

    // Reference: expected hit and the cycle (relative to the start edge T)
    // in which done is high.
    task automatic model(input box_t to, input box_t oo, input int tc, input int oc,
                         output int e_hit, output int e_lat);
        bit found;
        e_hit = 0;
        e_lat = 2;
        if (tc == 0 || oc == 0) return;
        if (!ovl(int'(to.x) + 1, int'(to.y) + 1, int'(to.w) - 2, int'(to.h) - 2,
                 int'(oo.x) + 1, int'(oo.y) + 1, int'(oo.w) - 2, int'(oo.h) - 2)) return;
        found = 0;
        for (int i = 0; i < tc && !found; i++) begin
            for (int j = 0; j < oc && !found; j++) begin
                if (ovl(int'(trex_tab[i].x) + int'(to.x), int'(trex_tab[i].y) + int'(to.y),
                        int'(trex_tab[i].w), int'(trex_tab[i].h),
                        int'(obs_tab[j].x) + int'(oo.x), int'(obs_tab[j].y) + int'(oo.y),
                        int'(obs_tab[j].w), int'(obs_tab[j].h))) begin
                    found = 1;
                    e_hit = 1;
                    e_lat = 3 + i * oc + j;
                end
            end
        end
        if (!found) e_lat = 2 + tc * oc;
    endtask

    // One complete check. With noise set, extra start pulses and changed
    // inputs are driven while the check is busy; the result must not move.
    task automatic run_check(input string tag, input box_t to, input box_t oo,
                             input int tc, input int oc, input bit noise);
        int e_hit, e_lat, tcc, occ, k, lat;
        bit in_inner;
        tcc = (tc > MT) ? MT : tc;
        occ = (oc > MO) ? MO : oc;
        model(to, oo, tcc, occ, e_hit, e_lat);
        @(negedge clk);
        trex_outer = to;
        obs_outer  = oo;
        trex_count = 4'(tc);
        obs_count  = 4'(oc);
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        k   = 1;
        while (k <= 100) begin
            @(negedge clk);
            in_inner = (e_lat > 2) && (k >= 2) && (k < e_lat);
            if (k == 1) check({tag, " hit_cleared"}, int'(hit), 0);
            check({tag, " busy"}, int'(busy), 1);
            check({tag, " trex_idx"}, int'(trex_idx), in_inner ? (k - 2) / occ : 0);
            check({tag, " obs_idx"},  int'(obs_idx),  in_inner ? (k - 2) % occ : 0);
            if (done) begin
                lat = k;
                break;
            end
            if (noise) begin
                start      = 1'b1;
                trex_outer = mk(int'($urandom_range(0, 300)), 0, 60, 60);
                obs_outer  = mk(int'($urandom_range(0, 300)), 0, 60, 60);
                trex_count = 4'($urandom_range(0, 15));
                obs_count  = 4'($urandom_range(0, 15));
            end
            k++;
        end
        start = 1'b0;
        check({tag, " latency"}, lat, e_lat);
        check({tag, " hit"}, int'(hit), e_hit);
        @(negedge clk);
        check({tag, " done_pulse"}, int'(done), 0);
        check({tag, " idle"}, int'(busy), 0);
        @(negedge clk);
        check({tag, " hit_held"}, int'(hit), e_hit);
    endtask

    task automatic fill_random_tables();
        for (int i = 0; i < MT; i++)
            trex_tab[i] = mk(int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
                             int'($urandom_range(1, 12)), int'($urandom_range(1, 12)));
        for (int i = 0; i < MO; i++)
            obs_tab[i] = mk(int'($urandom_range(0, 12)), int'($urandom_range(0, 30)),
                            int'($urandom_range(1, 8)), int'($urandom_range(1, 10)));
    endtask

    task automatic fill_disjoint_tables();
        // T-rex sub-boxes sit in the left part of the outer box, obstacle
        // sub-boxes far to the right: no pair can overlap.
        for (int i = 0; i < MT; i++) trex_tab[i] = mk(0, 5 * i, 5, 4);
        for (int i = 0; i < MO; i++) obs_tab[i]  = mk(12, 3 * i, 4, 3);
    endtask

    initial begin
        int tc, oc;
        box_t to, oo;
        rst_n      = 1'b0;
        start      = 1'b0;
        trex_outer = '0;
        obs_outer  = '0;
        trex_count = '0;
        obs_count  = '0;
        fill_disjoint_tables();

        #12;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset hit", int'(hit), 0);
        check("reset trex_idx", int'(trex_idx), 0);
        check("reset obs_idx", int'(obs_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Outer boxes far apart.
        run_check("outer_miss", mk(50, 93, 44, 47), mk(200, 105, 17, 35), 6, 3, 0);
        // Shrunk boxes only touch: 51+42 == 93.
        run_check("edge_touch", mk(50, 93, 44, 47), mk(92, 93, 17, 35), 6, 3, 0);

        // First pair overlaps.
        trex_tab[0] = mk(22, 0, 17, 16);
        obs_tab[0]  = mk(0, 0, 5, 27);
        run_check("early_hit", mk(50, 93, 44, 47), mk(75, 105, 17, 35), 6, 3, 0);

        // Full scan, no hit, index walk checked every cycle.
        fill_disjoint_tables();
        run_check("full_scan", mk(50, 93, 44, 47), mk(75, 105, 17, 35), 6, 3, 0);

        // Obstacle partly off-screen left.
        trex_tab[0] = mk(0, 10, 10, 10);
        obs_tab[0]  = mk(8, 0, 6, 30);
        run_check("neg_x", mk(2, 90, 44, 47), mk(-10, 100, 17, 30), 2, 2, 0);
        fill_disjoint_tables();
        run_check("neg_x_miss", mk(2, 90, 44, 47), mk(-10, 100, 17, 30), 2, 2, 0);

        // Start while busy is ignored; zero counts; clamped counts.
        run_check("busy_start", mk(50, 93, 44, 47), mk(75, 105, 17, 35), 6, 3, 1);
        run_check("zero_obs", mk(50, 93, 44, 47), mk(75, 105, 17, 35), 6, 0, 0);
        run_check("zero_trex", mk(50, 93, 44, 47), mk(75, 105, 17, 35), 0, 4, 0);
        run_check("clamp", mk(50, 93, 44, 47), mk(75, 105, 17, 35), 15, 9, 0);

        // Reset in the middle of a scan aborts without a done pulse.
        @(negedge clk);
        trex_outer = mk(50, 93, 44, 47);
        obs_outer  = mk(75, 105, 17, 35);
        trex_count = 4'd6;
        obs_count  = 4'd3;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_reset busy", int'(busy), 0);
        check("mid_reset done", int'(done), 0);
        check("mid_reset hit", int'(hit), 0);
        check("mid_reset trex_idx", int'(trex_idx), 0);
        check("mid_reset obs_idx", int'(obs_idx), 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("in_reset done", int'(done), 0);
        end
        rst_n = 1'b1;
        trex_tab[1] = mk(22, 0, 17, 16);
        obs_tab[2]  = mk(0, 0, 5, 27);
        run_check("after_reset", mk(50, 93, 44, 47), mk(75, 105, 17, 35), 6, 3, 0);

        // Randomized checks against the model.
        for (int r = 0; r < 60; r++) begin
            fill_random_tables();
            to = mk(int'($urandom_range(0, 90)) - 10, int'($urandom_range(80, 100)),
                    44, 47);
            oo = mk(int'($urandom_range(0, 160)) - 20, int'($urandom_range(90, 120)),
                    int'($urandom_range(10, 50)), int'($urandom_range(20, 40)));
            tc = int'($urandom_range(0, MT));
            oc = int'($urandom_range(0, MO));
            if (r % 8 == 3) tc = int'($urandom_range(9, 15));
            if (r % 8 == 5) oc = int'($urandom_range(9, 15));
            run_check($sformatf("rand%0d", r), to, oo, tc, oc, (r % 4) == 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/collision_checker.md
Name: collision_checker

Overview:
- Sequential collision detector for the T-rex game. Runs once per frame after entity positions update, and feeds the game-over logic.
- Performs a coarse outer-bounding-box test, then, only if that passes, walks every (T-rex sub-box, obstacle sub-box) pair, one pair per cycle.
- Sub-box geometry (relative to entity origin) is read combinationally from two external box tables through index ports.
- Box type is the 44-bit packed collision box from collision_pkg: x s12, y s12, w s10, h s10.

Parameters:
MAX_TREX_BOXES, 8, capacity of T-rex sub-box table; index width TI = $clog2(MAX_TREX_BOXES)
MAX_OBS_BOXES, 8, capacity of obstacle sub-box table; index width OI = $clog2(MAX_OBS_BOXES)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a check; ignored unless idle
trex_outer  in  44  T-rex outer box in absolute screen coordinates
obs_outer  in  44  obstacle outer box in absolute screen coordinates
trex_count  in  TI+1  number of valid T-rex sub-boxes, 0..MAX_TREX_BOXES
obs_count  in  OI+1  number of valid obstacle sub-boxes, 0..MAX_OBS_BOXES
trex_idx  out  TI  T-rex sub-box table read index
trex_box  in  44  relative sub-box at trex_idx, same cycle
obs_idx  out  OI  obstacle sub-box table read index
obs_box  in  44  relative sub-box at obs_idx, same cycle
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when the result is valid
hit  out  1  result of the last completed check; held until next start

Behaviour:
- States: IDLE, OUTER, INNER, DONE.
- Reset (async, rst_n low): state IDLE, busy=0, done=0, hit=0, trex_idx=0, obs_idx=0, internal i/j counters 0, latched inputs 0.
- IDLE: on start=1, latch trex_outer, obs_outer, trex_count and obs_count at the edge. Clear hit to 0 at the same edge. Go to OUTER.
- start while busy is ignored. Latched values must not change mid-check.
- OUTER: shrink each latched outer box to {x+1, y+1, w-2, h-2} and compare with box_compare semantics.
  - Overlap is strict-inequality AABB overlap, so touching edges are a miss.
  - Miss, or trex_count==0, or obs_count==0: go to DONE, hit=0.
  - Overlap: go to INNER with i=0, j=0.
- INNER: each cycle, trex_idx=i and obs_idx=j.
  - Adjust T-rex sub-box by latched trex_outer.x/.y, and obstacle sub-box by obs_outer.x/.y, as create_adjusted_collision_box does.
  - Compare the two adjusted boxes.
  - Overlap: go to DONE, hit=1 (early exit).
  - Otherwise j++. When j==obs_count-1, set j=0 and i++.
  - When i==trex_count-1 and j==obs_count-1 with no overlap: go to DONE, hit=0.
- DONE: done=1 for exactly this one cycle, then IDLE. hit is registered on entry to DONE and holds through IDLE.
- Index outputs are driven 0 outside INNER.
- Arithmetic: x+w and y+h are sign-extended to 13 bits before comparison, so nothing wraps. Negative x (obstacle partly off-screen left) must compare correctly.
- Latency, with start sampled at edge T:
  - OUTER occupies cycle T+1.
  - Outer miss: done in T+2.
  - First-pair hit: done in T+3.
  - Full inner miss: done in T+2+trex_count*obs_count.
- Counts above MAX are out of spec. The implementation clamps them to MAX.
- Reset asserted mid-check aborts immediately to the reset state. No done pulse is produced.

Test Plan:
1. Outer miss: trex_outer={50,93,44,47}, obs_outer={200,105,17,35}, start -> done at T+2, hit=0, trex_idx/obs_idx stay 0.
2. Edge touch: trex_outer={50,93,44,47}, obs_outer={92,93,17,35}. Shrunk boxes touch but do not overlap (51+42=93 is not >93) -> done T+2, hit=0.
3. Early inner hit: outer boxes overlap; trex table[0]={22,0,17,16}; obs table[0]={0,0,5,27}; trex x=50, obs x=75 -> hit=1, done at T+3.
4. Full inner scan, no hit: counts 6 and 3, outer overlap, sub-boxes disjoint -> done at T+20, hit=0. Index sequence (0,0),(0,1),(0,2),(1,0)…(5,2).
5. Negative x: obs_outer.x=-10, w=17, trex_outer.x=2, w=44 -> outer overlap detected. An inner pair overlapping at x≈0 gives hit=1.
6. Robustness: start while busy is ignored; zero obs_count -> done T+2, hit=0; rst_n low during INNER -> outputs 0 immediately, no done, next start works normally.
